renkon_ctrl_chain: RTL
======================

Name: renkon_ctrl_chain

Overview:
Parametrised successor to the fixed core→conv→bias→relu→pool control chain. It carries start/valid/stop control tokens through STAGES post-processing stages. Each stage has a runtime-programmable latency and can be bypassed at runtime. It produces per-stage output-enable strobes, a final token stream, and a one-cycle ack when the chain drains. It sits between the layer core sequencer and the post-processing datapath.

Parameters:
STAGES, 4, number of post-processing stages in the chain
LATMAX, 8, maximum programmable latency per stage in cycles (≥1)
LATW, $clog2(LATMAX+1), width of each latency field

Ports:
clk  in  1  clock
xrst  in  1  synchronous active-high reset; 1 clears all state on the next clk edge
in_start  in  1  first-token marker from the core sequencer
in_valid  in  1  data-valid token
in_stop  in  1  last-token marker
stage_en  in  STAGES  per-stage enable; 0 = bypass
stage_lat  in  STAGES*LATW  packed per-stage latency, stage i at [i*LATW +: LATW]
stage_oe  out  STAGES  stage i output strobe (delayed valid at the stage output)
out_start  out  1  start token at the chain output
out_valid  out  1  valid token at the chain output
out_stop  out  1  stop token at the chain output
busy  out  1  high from accepted start until ack
ack  out  1  one-cycle pulse, chain drained
err  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0, all delay lines cleared, FSM = IDLE. Reset mid-operation discards in-flight tokens and emits no ack.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE→RUN: on in_start=1. Same cycle latches stage_en and stage_lat into shadow registers. Config changes later in the run are ignored.
- RUN→DRAIN: on in_stop=1 (may coincide with in_start for a single-token run).
- DRAIN→DONE: when the stop token appears at out_stop.
- DONE→IDLE: after one cycle. ack=1 in DONE only, so ack follows out_stop by exactly 1 cycle.
- busy: 1 in RUN, DRAIN and DONE.
- Latency: latched stage_lat=0 is treated as 1; values above LATMAX saturate to LATMAX.
- Enabled stage i delays {start,valid,stop} by L_i cycles. A bypassed stage adds 0 cycles and holds stage_oe[i]=0.
- stage_oe[i] = delayed valid at stage i output, when enabled.
- A final output register adds 1 cycle. Total output latency = 1 + Σ L_i over enabled stages.
- All three token bits travel in lockstep; start and stop never reorder relative to valid.
- Tokens are accepted on every cycle in RUN (no backpressure). The chain behaves as a shift register, so back-to-back valids stay back-to-back.
- Inputs are ignored in IDLE, except in_start.
- Protocol errors set err=1. err stays set until xrst.
  - in_start in RUN, DRAIN or DONE: the token is dropped and does not propagate.
  - in_valid or in_stop while in DRAIN or DONE: the token is dropped.
- A new in_start is accepted in the cycle the FSM returns to IDLE, not in DONE.

Optional Feature:
RENKON_CHAIN_CNT_EN
- Defined:
  - Adds 16-bit counters of tokens entering (in_valid accepted in RUN) and leaving (out_valid).
  - Both counters clear on an accepted start.
  - In DONE, if the two counts differ, err is set.
  - Adds output port tok_cnt[15:0], the leaving count, held until the next start.
- Undefined: no counters and no tok_cnt port; err is driven only by the protocol checks.

Decomposition:
- Shared package renkon_ctrl_pkg:
  - ctrl_tok_t packed struct {start, valid, stop}.
  - chain_state_t enum {IDLE, RUN, DRAIN, DONE}.
  - Function sat_lat(lat, LATMAX) implementing the 0→1 and saturation rules.
- One sub-module, renkon_ctrl_delay:
  - Variable-depth (1..LATMAX) ctrl_tok_t delay line with a bypass input.
  - Instantiated STAGES times in a generate loop.

Test Plan:
- STAGES=4, all enabled, lat={1,2,3,4}; start+valid at t0, valids t1..t4, stop at t5 → out_start at t11, out_stop at t16, ack at t17; stage_oe[3] first high at t10.
- en=4'b0101, lat={2,X,3,X} → total latency 6. stage_oe[1] and stage_oe[3] stay 0. Toggling stage_lat mid-run has no effect.
- lat values 0 and 15 with LATMAX=8 → each behaves as 1 and 8 cycles respectively; total latency = 1+1+8 for two enabled stages.
- in_start pulsed again during RUN → err=1, and exactly one out_start observed. A new start one cycle after ack is accepted normally.
- xrst pulsed while tokens are in flight → all outputs 0 next cycle, no ack, and no residual tokens emerge afterwards.
- With RENKON_CHAIN_CNT_EN defined: 37 valids → tok_cnt=37 and err=0. Also force a valid during DRAIN → the valid is dropped and err=1.

Source files
------------

// File: rtl/renkon_ctrl_pkg.sv
// Shared types for the renkon control-token chain: token struct, chain FSM states
// and the latency sanitising helper.
package renkon_ctrl_pkg;

  typedef struct packed {
    logic start;
    logic valid;
    logic stop;
  } ctrl_tok_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chain_state_t;

  // A programmed latency of 0 means 1 cycle; anything above latmax clamps to latmax.
  function automatic int sat_lat(input int lat, input int latmax);
    if (lat == 0) return 1;
    if (lat > latmax) return latmax;
    return lat;
  endfunction

endpackage

// File: rtl/renkon_ctrl_delay.sv
// Variable-depth (1..LATMAX) delay line for one start/valid/stop token with bypass.
// Entries past the selected tap are cleared so stale tokens can never reappear.
module renkon_ctrl_delay
  import renkon_ctrl_pkg::*;
#(
  parameter int LATMAX = 8,
  parameter int LATW   = $clog2(LATMAX + 1)
) (
  input  logic            clk,
  input  logic            xrst,
  input  logic            bypass_i,
  input  logic [LATW-1:0] lat_i,
  input  logic [2:0]      tok_i,
  output logic [2:0]      tok_o
);

  ctrl_tok_t sr_q [LATMAX];
  int        lat_eff;

  assign lat_eff = sat_lat(int'(lat_i), LATMAX);

  always_ff @(posedge clk) begin
    if (xrst) begin
      for (int k = 0; k < LATMAX; k++) sr_q[k] <= '0;
    end else begin
      sr_q[0] <= bypass_i ? '0 : ctrl_tok_t'(tok_i);
      for (int k = 1; k < LATMAX; k++) begin
        sr_q[k] <= (k < lat_eff) ? sr_q[k-1] : '0;
      end
    end
  end

  always_comb begin
    tok_o = tok_i;
    if (!bypass_i) begin
      tok_o = '0;
      for (int k = 0; k < LATMAX; k++) begin
        if (lat_eff == k + 1) tok_o = sr_q[k];
      end
    end
  end

endmodule

// File: rtl/renkon_ctrl_chain.sv
// Control-token chain through STAGES runtime-configurable delay stages with drain ack.
// Define RENKON_CHAIN_CNT_EN to add in/out token counters, the tok_cnt port and a count check.
//   state | meaning
//   IDLE  | waiting for in_start; live config steers the first token
//   RUN   | accepting valid/stop tokens every cycle
//   DRAIN | stop accepted, waiting for it at out_stop
//   DONE  | one-cycle ack
module renkon_ctrl_chain
  import renkon_ctrl_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int LATMAX = 8,
  parameter int LATW   = $clog2(LATMAX + 1)
) (
  input  logic                   clk,
  input  logic                   xrst,
  input  logic                   in_start,
  input  logic                   in_valid,
  input  logic                   in_stop,
  input  logic [STAGES-1:0]      stage_en,
  input  logic [STAGES*LATW-1:0] stage_lat,
  output logic [STAGES-1:0]      stage_oe,
  output logic                   out_start,
  output logic                   out_valid,
  output logic                   out_stop,
  output logic                   busy,
  output logic                   ack,
  output logic                   err
`ifdef RENKON_CHAIN_CNT_EN
  ,
  output logic [15:0]            tok_cnt
`endif
);

  chain_state_t           state_q, state_d;
  logic [STAGES-1:0]      en_q, en_eff;
  logic [STAGES*LATW-1:0] lat_q, lat_eff;
  logic                   err_q, err_d;
  logic                   latch_cfg;
  logic                   cnt_mismatch;
  ctrl_tok_t              tok_in, out_q;
  ctrl_tok_t              chain_tok [STAGES+1];

`ifdef RENKON_CHAIN_CNT_EN
  logic [15:0] in_cnt_q, out_cnt_q;

  always_ff @(posedge clk) begin
    if (xrst) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else if (latch_cfg) begin
      in_cnt_q  <= {15'd0, in_valid};
      out_cnt_q <= '0;
    end else begin
      if (tok_in.valid) in_cnt_q  <= in_cnt_q + 16'd1;
      if (out_q.valid)  out_cnt_q <= out_cnt_q + 16'd1;
    end
  end

  assign cnt_mismatch = (in_cnt_q != out_cnt_q);
  assign tok_cnt      = out_cnt_q;
`else
  assign cnt_mismatch = 1'b0;
`endif

  // The start token enters before the shadow registers load, so IDLE uses the live config.
  assign en_eff  = (state_q == IDLE) ? stage_en  : en_q;
  assign lat_eff = (state_q == IDLE) ? stage_lat : lat_q;

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    latch_cfg = 1'b0;
    tok_in    = '0;
    case (state_q)
      IDLE: begin
        if (in_start) begin
          tok_in.start = 1'b1;
          tok_in.valid = in_valid;
          tok_in.stop  = in_stop;
          latch_cfg    = 1'b1;
          state_d      = in_stop ? DRAIN : RUN;
        end
      end
      RUN: begin
        tok_in.valid = in_valid;
        tok_in.stop  = in_stop;
        if (in_start) err_d = 1'b1;
        if (in_stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (in_start || in_valid || in_stop) err_d = 1'b1;
        if (out_q.stop) state_d = DONE;
      end
      DONE: begin
        if (in_start || in_valid || in_stop || cnt_mismatch) err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q <= IDLE;
      en_q    <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      out_q   <= chain_tok[STAGES];
      if (latch_cfg) begin
        en_q  <= stage_en;
        lat_q <= stage_lat;
      end
    end
  end

  assign chain_tok[0] = tok_in;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    renkon_ctrl_delay #(
      .LATMAX(LATMAX),
      .LATW  (LATW)
    ) u_dly (
      .clk     (clk),
      .xrst    (xrst),
      .bypass_i(~en_eff[i]),
      .lat_i   (lat_eff[i*LATW +: LATW]),
      .tok_i   (chain_tok[i]),
      .tok_o   (chain_tok[i+1])
    );
  end

  always_comb begin
    stage_oe = '0;
    for (int i = 0; i < STAGES; i++) begin
      stage_oe[i] = en_eff[i] & chain_tok[i+1].valid;
    end
  end

  assign out_start = out_q.start;
  assign out_valid = out_q.valid;
  assign out_stop  = out_q.stop;
  assign busy      = (state_q != IDLE);
  assign ack       = (state_q == DONE);
  assign err       = err_q;

endmodule
